// File: rtl/sine_top.sv
// Free-running 512-sample, 10-bit offset-binary sine generator driving DAC pins directly.
// Build option SINE_QUARTER_ROM_EN: quarter-wave ROM with mirroring instead of a full-period table.
module sine_top (
    input  logic clk,
    input  logic rst_n,
    output logic _9b,
    output logic _6a,
    output logic _4a,
    output logic _2a,
    output logic _0a,
    output logic _5a,
    output logic _3b,
    output logic _49a,
    output logic _45a,
    output logic _48b
);

    // round(511*sin(2*pi*k/512)), k = 0..128
    localparam logic [8:0] QTAB [0:128] = '{
        9'd0,   9'd6,   9'd13,  9'd19,  9'd25,  9'd31,  9'd38,  9'd44,
        9'd50,  9'd56,  9'd63,  9'd69,  9'd75,  9'd81,  9'd87,  9'd94,
        9'd100, 9'd106, 9'd112, 9'd118, 9'd124, 9'd130, 9'd136, 9'd142,
        9'd148, 9'd154, 9'd160, 9'd166, 9'd172, 9'd178, 9'd184, 9'd190,
        9'd196, 9'd201, 9'd207, 9'd213, 9'd218, 9'd224, 9'd230, 9'd235,
        9'd241, 9'd246, 9'd252, 9'd257, 9'd263, 9'd268, 9'd273, 9'd279,
        9'd284, 9'd289, 9'd294, 9'd299, 9'd304, 9'd309, 9'd314, 9'd319,
        9'd324, 9'd329, 9'd334, 9'd338, 9'd343, 9'd348, 9'd352, 9'd357,
        9'd361, 9'd366, 9'd370, 9'd374, 9'd379, 9'd383, 9'd387, 9'd391,
        9'd395, 9'd399, 9'd403, 9'd407, 9'd410, 9'd414, 9'd418, 9'd421,
        9'd425, 9'd428, 9'd432, 9'd435, 9'd438, 9'd441, 9'd445, 9'd448,
        9'd451, 9'd454, 9'd456, 9'd459, 9'd462, 9'd465, 9'd467, 9'd470,
        9'd472, 9'd474, 9'd477, 9'd479, 9'd481, 9'd483, 9'd485, 9'd487,
        9'd489, 9'd491, 9'd492, 9'd494, 9'd496, 9'd497, 9'd499, 9'd500,
        9'd501, 9'd502, 9'd503, 9'd505, 9'd505, 9'd506, 9'd507, 9'd508,
        9'd509, 9'd509, 9'd510, 9'd510, 9'd510, 9'd511, 9'd511, 9'd511,
        9'd511
    };

    // Within each half period, the second quarter reflects as 256-m, i.e. the
    // 8-bit two's complement of m; m = 128 maps onto itself (the peak).
    function automatic logic [9:0] sample_of(input logic [8:0] n);
        logic [7:0] m;
        logic [7:0] idx;
        logic [8:0] q;
        m   = n[7:0];
        idx = m[7] ? (~m + 8'd1) : m;
        q   = QTAB[idx];
        return n[8] ? (10'd512 - {1'b0, q}) : (10'd512 + {1'b0, q});
    endfunction

    logic [8:0] phase;
    logic [8:0] phase_next;
    logic [9:0] sample;
    logic [9:0] lut_next;

    assign phase_next = phase + 9'd1;

`ifdef SINE_QUARTER_ROM_EN
    always_comb begin
        lut_next = sample_of(phase_next);
    end
`else
    logic [9:0] full_rom [0:511];

    for (genvar g = 0; g < 512; g++) begin : g_rom
        assign full_rom[g] = sample_of(9'(g));
    end

    always_comb begin
        lut_next = full_rom[phase_next];
    end
`endif

    // The sample is looked up one phase ahead so the pins show S[k] on edge k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 9'd0;
            sample <= 10'd512;
        end else begin
            phase  <= phase_next;
            sample <= lut_next;
        end
    end

    assign _9b  = sample[0];
    assign _6a  = sample[1];
    assign _4a  = sample[2];
    assign _2a  = sample[3];
    assign _0a  = sample[4];
    assign _5a  = sample[5];
    assign _3b  = sample[6];
    assign _49a = sample[7];
    assign _45a = sample[8];
    assign _48b = sample[9];

endmodule

// File: tb/tb_sine_top.sv
// Directed bench for sine_top: reset behaviour, key samples, a sine reference sweep,
// periodicity, symmetry and an asynchronous mid-run reset.
module tb_sine_top;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic _9b, _6a, _4a, _2a, _0a, _5a, _3b, _49a, _45a, _48b;
    logic [9:0] pins;

    int err_cnt = 0;
    int chk_cnt = 0;
    int trace [1536];
    int sym [512];

    sine_top dut (
        .clk  (clk),
        .rst_n(rst_n),
        ._9b  (_9b),
        ._6a  (_6a),
        ._4a  (_4a),
        ._2a  (_2a),
        ._0a  (_0a),
        ._5a  (_5a),
        ._3b  (_3b),
        ._49a (_49a),
        ._45a (_45a),
        ._48b (_48b)
    );

    always #5 clk = ~clk;

    assign pins = {_48b, _45a, _49a, _3b, _5a, _0a, _2a, _4a, _6a, _9b};

    task automatic check_val(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_sample(input int n);
        real v;
        v = 511.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 512.0);
        if (v >= 0.0) return 512 + int'($floor(v + 0.5));
        else          return 512 - int'($floor(-v + 0.5));
    endfunction

    initial begin
        int bad;
        int lo;
        int hi;

        rst_n = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check_val("reset_hold", int'(pins), 512);
        end

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("release_pre_edge", int'(pins), 512);

        for (int k = 1; k <= 1536; k++) begin
            @(posedge clk);
            #1;
            trace[k-1] = int'(pins);
        end

        check_val("edge1",    trace[0],    518);
        check_val("edge2",    trace[1],    525);
        check_val("edge32",   trace[31],   708);
        check_val("edge64",   trace[63],   873);
        check_val("edge128",  trace[127],  1023);
        check_val("edge256",  trace[255],  512);
        check_val("edge384",  trace[383],  1);
        check_val("edge511",  trace[510],  506);
        check_val("edge512",  trace[511],  512);
        check_val("edge513",  trace[512],  518);
        check_val("edge1024", trace[1023], 512);

        bad = 0;
        for (int k = 1; k <= 1536; k++)
            if (trace[k-1] != ref_sample(k % 512)) bad++;
        check_val("ref_sweep_bad", bad, 0);

        bad = 0;
        for (int i = 0; i < 512; i++)
            if (trace[i] != trace[i+512] || trace[i] != trace[i+1024]) bad++;
        check_val("period_bad", bad, 0);

        lo = 2000;
        hi = -1;
        for (int i = 0; i < 1536; i++) begin
            if (trace[i] < lo) lo = trace[i];
            if (trace[i] > hi) hi = trace[i];
        end
        check_val("min", lo, 1);
        check_val("max", hi, 1023);

        sym[0] = trace[511];
        for (int n = 1; n < 512; n++) sym[n] = trace[n-1];
        bad = 0;
        for (int n = 0; n < 512; n++)
            if (sym[n] + sym[(512 - n) % 512] != 1024) bad++;
        check_val("odd_sym_bad", bad, 0);
        bad = 0;
        for (int n = 0; n <= 256; n++)
            if (sym[n] != sym[256 - n]) bad++;
        check_val("mirror_sym_bad", bad, 0);

        repeat (300) @(posedge clk);
        #1;
        check_val("edge300", int'(pins), 249);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset", int'(pins), 512);
        @(posedge clk);
        #1;
        check_val("reset_held", int'(pins), 512);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("restart_edge1", int'(pins), 518);
        @(posedge clk);
        #1;
        check_val("restart_edge2", int'(pins), 525);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
